// File: rtl/mem_access_unit_if.sv
// Command handshake and instruction/data memory port bundle for mem_access_unit.
// The slave modport is the unit's side; master is the control-unit/memory side.
interface mem_access_unit_if #(
  parameter int reg_width  = 12,
  parameter int addr_width = 12,
  parameter int Im_width   = 8,
  parameter int burst_max  = 4
);
  localparam int bl_width = $clog2(burst_max + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic                  addr_sel;
  logic [addr_width-1:0] pc_datain;
  logic [reg_width-1:0]  bus_datain;
  logic [reg_width-1:0]  wdata;
  logic [bl_width-1:0]   burst_len;
  logic [addr_width-1:0] AR_dataout;
  logic [reg_width-1:0]  DR_dataout;
  logic                  rvalid;
  logic                  done;
  logic                  err;
  logic [Im_width-1:0]   im_address;
  logic [reg_width-1:0]  im_q;
  logic [addr_width-1:0] dm_address;
  logic [reg_width-1:0]  dm_data;
  logic                  dm_wren;
  logic [reg_width-1:0]  dm_q;

  modport slave (
    input  cmd_valid, cmd_op, addr_sel, pc_datain, bus_datain, wdata, burst_len, im_q, dm_q,
    output cmd_ready, AR_dataout, DR_dataout, rvalid, done, err,
           im_address, dm_address, dm_data, dm_wren
  );

  modport master (
    output cmd_valid, cmd_op, addr_sel, pc_datain, bus_datain, wdata, burst_len, im_q, dm_q,
    input  cmd_ready, AR_dataout, DR_dataout, rvalid, done, err,
           im_address, dm_address, dm_data, dm_wren
  );
endinterface

// File: rtl/mem_access_unit.sv
// AR/DR memory access unit: single writes, instruction reads, bursting data reads.
// Read beat k lands in DR (k+1)*(read_latency+1) edges after accept; cmd_ready only when idle.
module mem_access_unit #(
  parameter int reg_width    = 12,
  parameter int addr_width   = 12,
  parameter int Im_width     = 8,
  parameter int read_latency = 1,
  parameter int burst_max    = 4
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave mau
);
  localparam int bl_width  = $clog2(burst_max + 1);
  localparam int lat_width = $clog2(read_latency + 1);

  typedef enum logic [1:0] {IDLE, RWAIT, WRITE} state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] ar, ar_nxt;
  logic [reg_width-1:0]  dr, dr_nxt;
  logic                  is_instr, is_instr_nxt;
  logic [bl_width-1:0]   beats, beats_nxt;
  logic [lat_width-1:0]  lat_cnt, lat_cnt_nxt;
  logic                  rvalid, rvalid_nxt;
  logic                  done, done_nxt;
  logic                  err, err_nxt;
  logic [bl_width-1:0]   blen_eff;

  // Zero-length bursts still read one beat; oversize bursts saturate.
  always_comb begin
    blen_eff = mau.burst_len;
    if (mau.burst_len == '0)
      blen_eff = bl_width'(1);
    else if (mau.burst_len > bl_width'(burst_max))
      blen_eff = bl_width'(burst_max);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ar       <= '0;
      dr       <= '0;
      is_instr <= 1'b0;
      beats    <= '0;
      lat_cnt  <= '0;
      rvalid   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ar       <= ar_nxt;
      dr       <= dr_nxt;
      is_instr <= is_instr_nxt;
      beats    <= beats_nxt;
      lat_cnt  <= lat_cnt_nxt;
      rvalid   <= rvalid_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ar_nxt       = ar;
    dr_nxt       = dr;
    is_instr_nxt = is_instr;
    beats_nxt    = beats;
    lat_cnt_nxt  = lat_cnt;
    rvalid_nxt   = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (mau.cmd_valid) begin
          ar_nxt       = mau.addr_sel ? mau.pc_datain : mau.bus_datain[addr_width-1:0];
          is_instr_nxt = (mau.cmd_op == 2'b00);
          beats_nxt    = (mau.cmd_op[0] == 1'b0) ? bl_width'(1) : blen_eff;
          lat_cnt_nxt  = lat_width'(read_latency);
          if (mau.cmd_op == 2'b10) begin
            dr_nxt    = mau.wdata;
            state_nxt = WRITE;
          end else begin
            state_nxt = RWAIT;
          end
        end
      end
      WRITE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      RWAIT: begin
        if (lat_cnt != '0) begin
          lat_cnt_nxt = lat_cnt - lat_width'(1);
        end else begin
          dr_nxt     = is_instr ? mau.im_q : mau.dm_q;
          rvalid_nxt = 1'b1;
          if (beats > bl_width'(1)) begin
            beats_nxt   = beats - bl_width'(1);
            ar_nxt      = ar + addr_width'(1);
            lat_cnt_nxt = lat_width'(read_latency);
          end else begin
            beats_nxt = '0;
            done_nxt  = 1'b1;
            // Out-of-range instruction fetch still returns the truncated-address word.
            err_nxt   = is_instr && ((ar >> Im_width) != '0);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mau.cmd_ready  = (state == IDLE);
  assign mau.dm_wren    = (state == WRITE);
  assign mau.AR_dataout = ar;
  assign mau.DR_dataout = dr;
  assign mau.im_address = ar[Im_width-1:0];
  assign mau.dm_address = ar;
  assign mau.dm_data    = dr;
  assign mau.rvalid     = rvalid;
  assign mau.done       = done;
  assign mau.err        = err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: latency-1 and latency-3 instances against sync-RAM models.
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       t_valid [2];
  logic [1:0] t_op;
  logic       t_sel;
  logic [11:0] t_pc, t_bus, t_wd;
  logic [2:0] t_blen;
  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit_if ifa ();
  mem_access_unit_if ifb ();

  mem_access_unit #(.read_latency(1)) u_l1 (.clk(clk), .reset(rst_n[0]), .mau(ifa));
  mem_access_unit #(.read_latency(3)) u_l3 (.clk(clk), .reset(rst_n[1]), .mau(ifb));

  assign ifa.cmd_valid = t_valid[0];
  assign ifb.cmd_valid = t_valid[1];
  assign ifa.cmd_op = t_op;       assign ifb.cmd_op = t_op;
  assign ifa.addr_sel = t_sel;    assign ifb.addr_sel = t_sel;
  assign ifa.pc_datain = t_pc;    assign ifb.pc_datain = t_pc;
  assign ifa.bus_datain = t_bus;  assign ifb.bus_datain = t_bus;
  assign ifa.wdata = t_wd;        assign ifb.wdata = t_wd;
  assign ifa.burst_len = t_blen;  assign ifb.burst_len = t_blen;

  logic [11:0] o_ar [2], o_dr [2], o_dma [2], o_dmd [2];
  logic [7:0]  o_ima [2];
  logic        o_rdy [2], o_rv [2], o_done [2], o_err [2], o_wren [2];
  assign o_ar[0] = ifa.AR_dataout;   assign o_ar[1] = ifb.AR_dataout;
  assign o_dr[0] = ifa.DR_dataout;   assign o_dr[1] = ifb.DR_dataout;
  assign o_dma[0] = ifa.dm_address;  assign o_dma[1] = ifb.dm_address;
  assign o_dmd[0] = ifa.dm_data;     assign o_dmd[1] = ifb.dm_data;
  assign o_ima[0] = ifa.im_address;  assign o_ima[1] = ifb.im_address;
  assign o_rdy[0] = ifa.cmd_ready;   assign o_rdy[1] = ifb.cmd_ready;
  assign o_rv[0] = ifa.rvalid;       assign o_rv[1] = ifb.rvalid;
  assign o_done[0] = ifa.done;       assign o_done[1] = ifb.done;
  assign o_err[0] = ifa.err;         assign o_err[1] = ifb.err;
  assign o_wren[0] = ifa.dm_wren;    assign o_wren[1] = ifb.dm_wren;

  // Synchronous RAMs: q appears read_latency edges after the address is sampled.
  logic [11:0] im [256];
  logic [11:0] dm0 [4096];
  logic [11:0] dm1 [4096];
  logic [3:0][11:0] ip0, ip1, dp0, dp1;
  int fill_idx = 0;

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 37 + 5) ^ 12'h5A5;
  endfunction

  always @(posedge clk) begin
    ip0 <= {ip0[2:0], im[o_ima[0]]};
    ip1 <= {ip1[2:0], im[o_ima[1]]};
    dp0 <= {dp0[2:0], dm0[o_dma[0]]};
    dp1 <= {dp1[2:0], dm1[o_dma[1]]};
    if (fill_idx < 4096) begin
      dm0[fill_idx[11:0]] <= pat(fill_idx);
      dm1[fill_idx[11:0]] <= pat(fill_idx);
      fill_idx <= fill_idx + 1;
    end else begin
      if (o_wren[0]) dm0[o_dma[0]] <= o_dmd[0];
      if (o_wren[1]) dm1[o_dma[1]] <= o_dmd[1];
    end
  end

  assign ifa.im_q = ip0[0];
  assign ifa.dm_q = dp0[0];
  assign ifb.im_q = ip1[2];
  assign ifb.dm_q = dp1[2];

  // Reference data memory contents, updated only when the model retires a write.
  logic [11:0] ref_dm0 [4096];
  logic [11:0] ref_dm1 [4096];

  function automatic logic [11:0] ref_rd(input int w, input logic [11:0] a);
    return (w == 0) ? ref_dm0[a] : ref_dm1[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_reset(input int w);
    chk("rst_cmd_ready", 32'(o_rdy[w]), 1);
    chk("rst_rvalid", 32'(o_rv[w]), 0);
    chk("rst_done", 32'(o_done[w]), 0);
    chk("rst_err", 32'(o_err[w]), 0);
    chk("rst_dm_wren", 32'(o_wren[w]), 0);
    chk("rst_ar", 32'(o_ar[w]), 0);
    chk("rst_dr", 32'(o_dr[w]), 0);
  endtask

  // Issues one command at a falling edge and checks every following cycle up to done.
  // Returns at the falling edge of the done cycle so the next call lands back-to-back.
  task automatic run_cmd(input int w, input logic [1:0] op, input logic sel,
                         input logic [11:0] pc, input logic [11:0] bus, input logic [11:0] wd,
                         input logic [2:0] blen, input bit pulse, input int abort_at);
    int lat, beats, total, k;
    logic [11:0] addr, exp_ar;
    bit wr, instr, rv_e, done_e;
    lat   = (w == 0) ? 1 : 3;
    wr    = (op == 2'b10);
    instr = (op == 2'b00);
    addr  = sel ? pc : bus;
    beats = (wr || instr) ? 1 : (blen == 3'd0) ? 1 : (blen > 3'd4) ? 4 : int'(blen);
    total = wr ? 1 : beats * (lat + 1);
    t_op = op; t_sel = sel; t_pc = pc; t_bus = bus; t_wd = wd; t_blen = blen;
    t_valid[w] = 1'b1;
    chk("ready_before_accept", 32'(o_rdy[w]), 1);
    @(posedge clk);
    #1 t_valid[w] = 1'b0;
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      rv_e   = !wr && c > 0 && (c % (lat + 1)) == 0;
      done_e = (c == total);
      k = c / (lat + 1);
      if (k > beats - 1) k = beats - 1;
      exp_ar = addr + 12'(k);
      chk("ar", 32'(o_ar[w]), 32'(exp_ar));
      chk("dm_address", 32'(o_dma[w]), 32'(exp_ar));
      chk("im_address", 32'(o_ima[w]), 32'(exp_ar[7:0]));
      chk("rvalid", 32'(o_rv[w]), 32'(rv_e));
      chk("done", 32'(o_done[w]), 32'(done_e));
      chk("err", 32'(o_err[w]), 32'(done_e && instr && addr[11:8] != 4'h0));
      chk("cmd_ready", 32'(o_rdy[w]), 32'(done_e));
      chk("dm_wren", 32'(o_wren[w]), 32'(wr && c == 0));
      if (wr) begin
        chk("dr_wdata", 32'(o_dr[w]), 32'(wd));
        chk("dm_data", 32'(o_dmd[w]), 32'(wd));
      end else if (rv_e) begin
        chk("dr_beat", 32'(o_dr[w]),
            32'(instr ? im[addr[7:0]] : ref_rd(w, addr + 12'(c / (lat + 1) - 1))));
      end
      if (c == abort_at) begin
        rst_n[w] = 1'b0;
        #1 check_reset(w);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", 32'(o_done[w]), 0);
          chk("abort_ready", 32'(o_rdy[w]), 1);
        end
        rst_n[w] = 1'b1;
        return;
      end
      if (pulse && c < total - 1) begin
        t_valid[w] = 1'b1;
        t_pc  = 12'($urandom);
        t_bus = 12'($urandom);
      end else begin
        t_valid[w] = 1'b0;
      end
    end
    if (wr) begin
      if (w == 0) ref_dm0[addr] = wd;
      else ref_dm1[addr] = wd;
    end
  endtask

  int r_w;
  logic [1:0] r_op;
  logic [2:0] r_blen;

  initial begin
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    t_valid[0] = 1'b0; t_valid[1] = 1'b0;
    t_op = 2'b00; t_sel = 1'b0; t_pc = '0; t_bus = '0; t_wd = '0; t_blen = '0;
    for (int i = 0; i < 256; i++) im[i] = 12'($urandom);
    im[8'h05] = 12'hA3C;
    for (int i = 0; i < 4096; i++) begin
      ref_dm0[i] = pat(i);
      ref_dm1[i] = pat(i);
    end
    #1 rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    repeat (4100) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    run_cmd(0, 2'b00, 1'b1, 12'h005, 12'hFFF, 12'h000, 3'd0, 1'b0, -1);
    chk("instr_read_a3c", 32'(o_dr[0]), 32'h0A3C);
    run_cmd(0, 2'b10, 1'b0, 12'h000, 12'hFFE, 12'h111, 3'd3, 1'b0, -1);
    run_cmd(0, 2'b10, 1'b0, 12'h000, 12'hFFF, 12'h222, 3'd0, 1'b0, -1);
    run_cmd(0, 2'b10, 1'b1, 12'h000, 12'h000, 12'h333, 3'd4, 1'b0, -1);
    run_cmd(0, 2'b10, 1'b1, 12'h001, 12'h000, 12'h444, 3'd1, 1'b0, -1);
    run_cmd(0, 2'b01, 1'b0, 12'h000, 12'hFFE, 12'h000, 3'd4, 1'b0, -1);
    chk("burst_last_444", 32'(o_dr[0]), 32'h0444);
    run_cmd(0, 2'b10, 1'b1, 12'h040, 12'h000, 12'h123, 3'd3, 1'b0, -1);
    run_cmd(0, 2'b01, 1'b1, 12'h040, 12'h000, 12'h000, 3'd1, 1'b0, -1);
    chk("readback_123", 32'(o_dr[0]), 32'h0123);
    run_cmd(0, 2'b00, 1'b0, 12'h000, 12'h1F0, 12'h000, 3'd0, 1'b0, -1);
    run_cmd(0, 2'b01, 1'b0, 12'h000, 12'h3A0, 12'h000, 3'd4, 1'b0, 5);
    run_cmd(0, 2'b01, 1'b0, 12'h000, 12'h3A0, 12'h000, 3'd1, 1'b0, -1);
    run_cmd(1, 2'b01, 1'b1, 12'h200, 12'h000, 12'h000, 3'd1, 1'b1, -1);
    run_cmd(1, 2'b01, 1'b1, 12'h300, 12'h000, 12'h000, 3'd0, 1'b1, -1);
    run_cmd(1, 2'b11, 1'b0, 12'h000, 12'h7FE, 12'h000, 3'd7, 1'b1, -1);
    run_cmd(1, 2'b10, 1'b0, 12'h000, 12'h7FF, 12'h5C5, 3'd2, 1'b0, -1);
    run_cmd(1, 2'b01, 1'b0, 12'h000, 12'h7FF, 12'h000, 3'd2, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      r_w    = int'($urandom_range(1, 0));
      r_op   = 2'($urandom);
      r_blen = 3'($urandom);
      run_cmd(r_w, r_op, 1'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
              r_blen, 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit that replaces the discrete AR/DR pair of the 12-bit processor datapath. It accepts read and write commands from the control unit over a valid/ready handshake. It drives the instruction memory and data memory ports, waits a configurable synchronous-RAM read latency, and returns read data through DR. Data reads support multi-beat bursts with AR auto-increment.

## Interface
- `reg_width`, 12, data and DR width
- `addr_width`, 12, AR and data-memory address width
- `Im_width`, 8, instruction-memory address width (≤ `addr_width`)
- `read_latency`, 1, RAM clock edges from address capture to q valid; legal range 1..4
- `burst_max`, 4, maximum beats per data-read burst

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  unit idle, command accepted on `cmd_valid & cmd_ready`
- `cmd_op`  in  2  00 instruction read, 01 data read, 10 data write, 11 reserved (treated as 01)
- `addr_sel`  in  1  1: address from `pc_datain`; 0: from `bus_datain`
- `pc_datain`  in  addr_width  PC value
- `bus_datain`  in  reg_width  bus address (low `addr_width` bits)
- `wdata`  in  reg_width  write data
- `burst_len`  in  $clog2(burst_max+1)  beats for data reads; 0 treated as 1, values > `burst_max` clamp to `burst_max`
- `AR_dataout`  out  addr_width  current address register
- `DR_dataout`  out  reg_width  data register
- `rvalid`  out  1  one-cycle pulse: new read beat in DR
- `done`  out  1  one-cycle pulse: command complete
- `err`  out  1  one-cycle pulse with `done`: instruction address out of range
- `im_address`  out  Im_width  `AR_dataout[Im_width-1:0]`
- `im_q`  in  reg_width  instruction memory output
- `dm_address`  out  addr_width  `AR_dataout`
- `dm_data`  out  reg_width  `DR_dataout`
- `dm_wren`  out  1  data memory write enable
- `dm_q`  in  reg_width  data memory output

## Operation
- States: IDLE, RWAIT, WRITE.
- `cmd_ready` = (state == IDLE). `cmd_valid` is ignored in any other state.
- Accept in IDLE:
  - AR loads the selected address.
  - Op, beat count and latency counter (= `read_latency`) latch.
  - Writes: DR loads `wdata` and the state goes to WRITE.
  - Reads: the state goes to RWAIT.
- WRITE:
  - `dm_wren` = 1 for exactly this one cycle.
  - Next edge: `done` = 1 and the state returns to IDLE.
  - Writes are always single-beat; `burst_len` is ignored.
- RWAIT:
  - The latency counter decrements each edge.
  - At the edge where the counter is 0, DR captures `im_q` (op 00) or `dm_q` (op 01) and `rvalid` is set.
  - If beats remain: AR increments modulo 2^`addr_width` (0xFFF → 0x000), the counter reloads and the state stays in RWAIT.
  - On the last beat: `done` is set with `rvalid` and the state goes to IDLE.
- Instruction reads are always single-beat. If `AR[addr_width-1:Im_width]` ≠ 0, `err` pulses with `done` and DR still takes `im_q` from the truncated address.
- `dm_wren` = 0 in every state except WRITE.

## Timing
- Reset values, applied immediately on reset assertion:
  - AR = 0, DR = 0, state = IDLE
  - `cmd_ready` = 1
  - `rvalid`, `done`, `err`, `dm_wren` = 0
  - Counters = 0
- Reset mid-command aborts it: no `done`, no write if asserted before the WRITE edge.
- Accept edge is E0. AR is valid on the memory address ports from E0.
- Read beat k (k = 0..n-1): DR updates at edge E0 + (k+1)(`read_latency`+1). `rvalid` is high for the following cycle.
- Write: `dm_wren` is high in cycle E0..E1 and memory captures at E1. `done` is high in E1..E2. `cmd_ready` is high from E1.
- After the last read beat, `cmd_ready` is high in the same cycle as the final `done`. A back-to-back command may be accepted at that cycle's edge.
- `rvalid`, `done` and `err` are registered; every other output follows state/AR/DR.

## Test plan
- Instruction read, default params: im[0x005] = 0xA3C; accept `cmd_op`=00, `addr_sel`=1, `pc_datain`=0x005 at E0 -> DR = 0xA3C at E2; `rvalid` = `done` = 1 in E2..E3; `err` = 0; `cmd_ready` = 1 in E2..E3.
- Burst data read from 0xFFE, `burst_len`=4, dm[0xFFE,0xFFF,0x000,0x001] = 0x111,0x222,0x333,0x444 -> DR takes those values at E2,E4,E6,E8; `done` only at E8; AR wraps to 0x000 at E4.
- Write then read back: write `wdata`=0x123 to 0x040 -> `dm_wren` high exactly one cycle, `done` at E1; immediate data read of 0x040 returns 0x123. With `burst_len`=3 on the write, still one write.
- Instruction read at 0x1F0, `Im_width`=8 -> `im_address` = 0xF0; DR = im[0xF0]; `err` = `done` = 1 for one cycle.
- Reset low during beat 2 of a 4-beat burst -> all outputs at reset values at once, no `done`. After release: `cmd_ready` = 1 and a new single read completes normally.
- Instance with `read_latency`=3: single data read captures at E4. `cmd_valid` pulsed at E1–E3 is ignored (AR unchanged). `burst_len`=0 gives one beat; `burst_len`=7 with `burst_max`=4 gives exactly 4 beats.
